// File: rtl/biss_frame_checker.sv
// BiSS-C frame checker: checks the CRC6 of each raw frame bit-serially, publishes
// CRC-clean positions with a wrapping delta, and tracks bad-frame faults and overruns.
module biss_frame_checker #(
   parameter int FAULT_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_valid,
   input  logic [40:0] enc_position_all,
   input  logic        fault_clr,
   output logic        pos_valid,
   output logic [31:0] pos_out,
   output logic [31:0] pos_delta,
   output logic        enc_err,
   output logic        enc_warn,
   output logic        crc_err,
   output logic        fault,
   output logic        overrun,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      CHECK  = 2'd2,
      UPDATE = 2'd3
   } state_t;

   localparam logic [3:0] LIMIT    = 4'(FAULT_LIMIT);
   localparam logic [5:0] LAST_BIT = 6'd33;

   // One step of the x^6+x+1 CRC, MSB-first
   function automatic logic [5:0] crc6_step(input logic [5:0] crc, input logic b);
      logic fb;
      fb = crc[5] ^ b;
      return {crc[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
   endfunction

   state_t      state_r;
   state_t      state_s;
   logic [39:0] frame_r;
   logic [39:0] shift_r;
   logic [5:0]  crc_r;
   logic [5:0]  bit_cnt_r;
   logic        good_r;
   logic [3:0]  consec_r;
   logic        seen_r;

   logic        good_upd_s;
   logic        bad_upd_s;
   logic [3:0]  consec_inc_s;
   logic        fault_set_s;
   logic        overrun_set_s;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = frame_valid ? CALC : IDLE;
         CALC:    state_s = (bit_cnt_r == LAST_BIT) ? CHECK : CALC;
         CHECK:   state_s = UPDATE;
         UPDATE:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Result decode shared by the output register
   always_comb begin
      good_upd_s    = (state_r == UPDATE) && good_r;
      bad_upd_s     = (state_r == UPDATE) && !good_r;
      consec_inc_s  = (consec_r >= LIMIT) ? LIMIT : (consec_r + 4'd1);
      fault_set_s   = bad_upd_s && (consec_inc_s >= LIMIT);
      overrun_set_s = frame_valid && (state_r != IDLE);
   end

   // Frame capture and serial CRC; the shift register walks bits [39:6] MSB first
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_r   <= 40'd0;
         shift_r   <= 40'd0;
         crc_r     <= 6'd0;
         bit_cnt_r <= 6'd0;
         good_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (frame_valid) begin
                  frame_r   <= enc_position_all[39:0];
                  shift_r   <= enc_position_all[39:0];
                  crc_r     <= 6'd0;
                  bit_cnt_r <= 6'd0;
               end else begin
                  bit_cnt_r <= bit_cnt_r;
               end
            end
            CALC: begin
               crc_r     <= crc6_step(crc_r, shift_r[39]);
               shift_r   <= {shift_r[38:0], 1'b0};
               bit_cnt_r <= bit_cnt_r + 6'd1;
            end
            CHECK: begin
               // BiSS sends the CRC inverted
               good_r <= (frame_r[5:0] == ~crc_r);
            end
            UPDATE: begin
               good_r <= good_r;
            end
            default: begin
               good_r <= 1'b0;
            end
         endcase
      end
   end

   // Published outputs, counters and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         pos_valid <= 1'b0;
         crc_err   <= 1'b0;
         pos_out   <= 32'd0;
         pos_delta <= 32'd0;
         enc_err   <= 1'b0;
         enc_warn  <= 1'b0;
         fault     <= 1'b0;
         overrun   <= 1'b0;
         good_cnt  <= 16'd0;
         bad_cnt   <= 16'd0;
         consec_r  <= 4'd0;
         seen_r    <= 1'b0;
      end else begin
         pos_valid <= good_upd_s;
         crc_err   <= bad_upd_s;

         if (good_upd_s) begin
            pos_delta <= seen_r ? (frame_r[39:8] - pos_out) : 32'd0;
            pos_out   <= frame_r[39:8];
            enc_err   <= frame_r[7];
            enc_warn  <= frame_r[6];
            seen_r    <= 1'b1;
            consec_r  <= 4'd0;
            if (good_cnt != 16'hFFFF) begin
               good_cnt <= good_cnt + 16'd1;
            end else begin
               good_cnt <= good_cnt;
            end
         end else if (bad_upd_s) begin
            consec_r <= consec_inc_s;
            if (bad_cnt != 16'hFFFF) begin
               bad_cnt <= bad_cnt + 16'd1;
            end else begin
               bad_cnt <= bad_cnt;
            end
         end else begin
            consec_r <= consec_r;
         end

         // Set beats a coincident clear
         if (fault_set_s) begin
            fault <= 1'b1;
         end else if (fault_clr) begin
            fault <= 1'b0;
         end else begin
            fault <= fault;
         end

         if (overrun_set_s) begin
            overrun <= 1'b1;
         end else if (fault_clr) begin
            overrun <= 1'b0;
         end else begin
            overrun <= overrun;
         end
      end
   end

endmodule

// File: tb/tb_biss_frame_checker.sv
// Directed bench for biss_frame_checker: CRC acceptance, delta wrap, fault/overrun
// stickiness, frame drop while busy and reset mid-frame.
module tb_biss_frame_checker;

   logic        clk;
   logic        reset;
   logic        frame_valid;
   logic [40:0] enc_position_all;
   logic        fault_clr;
   logic        pos_valid;
   logic [31:0] pos_out;
   logic [31:0] pos_delta;
   logic        enc_err;
   logic        enc_warn;
   logic        crc_err;
   logic        fault;
   logic        overrun;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;

   int checks = 0;
   int errors = 0;
   int pv_pulses = 0;
   int ce_pulses = 0;
   int both_high = 0;
   int pv_before;
   int ce_before;

   biss_frame_checker #(.FAULT_LIMIT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .frame_valid      (frame_valid),
      .enc_position_all (enc_position_all),
      .fault_clr        (fault_clr),
      .pos_valid        (pos_valid),
      .pos_out          (pos_out),
      .pos_delta        (pos_delta),
      .enc_err          (enc_err),
      .enc_warn         (enc_warn),
      .crc_err          (crc_err),
      .fault            (fault),
      .overrun          (overrun),
      .good_cnt         (good_cnt),
      .bad_cnt          (bad_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (pos_valid) pv_pulses++;
      if (crc_err) ce_pulses++;
      if (pos_valid && crc_err) both_high++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference CRC over {position, err, warn}, returned inverted as transmitted
   function automatic logic [5:0] model_crc(input logic [31:0] pos, input logic e, input logic w);
      logic [33:0] d;
      logic [5:0]  c;
      logic        fb;
      d = {pos, e, w};
      c = 6'd0;
      for (int i = 33; i >= 0; i--) begin
         fb = c[5] ^ d[i];
         c  = {c[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
      end
      return ~c;
   endfunction

   // Sends one frame and returns #1 after E36, optionally pulsing fault_clr into E36
   task automatic send(input logic [31:0] pos, input logic e, input logic w,
                       input logic [5:0] crc, input logic clr);
      @(negedge clk);
      frame_valid      = 1'b1;
      enc_position_all = {1'b1, pos, e, w, crc};
      @(posedge clk);
      #1 frame_valid = 1'b0;
      repeat (35) @(posedge clk);
      if (clr) fault_clr = 1'b1;
      @(posedge clk);
      #1 fault_clr = 1'b0;
   endtask

   task automatic send_good(input logic [31:0] pos, input logic e, input logic w);
      send(pos, e, w, model_crc(pos, e, w), 1'b0);
   endtask

   task automatic send_bad(input logic [31:0] pos, input logic clr);
      send(pos, 1'b0, 1'b0, model_crc(pos, 1'b0, 1'b0) ^ 6'h01, clr);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      fault_clr = 1'b1;
      @(posedge clk);
      #1 fault_clr = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pos_out"},   pos_out,   32'd0);
      check({tag, "_pos_delta"}, pos_delta, 32'd0);
      check({tag, "_flags"}, {26'd0, enc_err, enc_warn, pos_valid, crc_err, fault, overrun}, 32'd0);
      check({tag, "_good_cnt"},  {16'd0, good_cnt}, 32'd0);
      check({tag, "_bad_cnt"},   {16'd0, bad_cnt},  32'd0);
   endtask

   initial begin
      reset            = 1'b1;
      frame_valid      = 1'b0;
      enc_position_all = 41'd0;
      fault_clr        = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_state("rst");

      // All-zero payload: CRC register stays 0, so 6'h3F is the good CRC
      send(32'd0, 1'b0, 1'b0, 6'h3F, 1'b0);
      check("zero_pos_valid", {31'd0, pos_valid}, 32'd1);
      check("zero_crc_err",   {31'd0, crc_err},   32'd0);
      check("zero_pos_out",   pos_out,   32'd0);
      check("zero_delta",     pos_delta, 32'd0);
      check("zero_good_cnt",  {16'd0, good_cnt}, 32'd1);

      // Back-to-back (accepted at E37), same payload with CRC 0 -> rejected
      send(32'd0, 1'b0, 1'b0, 6'h00, 1'b0);
      check("bad0_crc_err",   {31'd0, crc_err},   32'd1);
      check("bad0_pos_valid", {31'd0, pos_valid}, 32'd0);
      check("bad0_pos_out",   pos_out,   32'd0);
      check("bad0_bad_cnt",   {16'd0, bad_cnt}, 32'd1);
      check("bad0_fault",     {31'd0, fault},   32'd0);

      send_good(32'hFFFF_FFFE, 1'b1, 1'b0);
      check("fffe_pos_out", pos_out,   32'hFFFF_FFFE);
      check("fffe_delta",   pos_delta, 32'hFFFF_FFFE);
      check("fffe_err_warn", {30'd0, enc_err, enc_warn}, 32'h2);

      send_good(32'h0000_0002, 1'b0, 1'b1);
      check("wrap_delta",    pos_delta, 32'h0000_0004);
      check("wrap_err_warn", {30'd0, enc_err, enc_warn}, 32'h1);
      check("wrap_good_cnt", {16'd0, good_cnt}, 32'd3);

      send_good(32'h0000_0100, 1'b0, 1'b0);
      send_good(32'h0000_00F0, 1'b0, 1'b0);
      check("neg_delta",    pos_delta, 32'hFFFF_FFF0);
      check("neg_pos_out",  pos_out,   32'h0000_00F0);

      // Bad frame holds published data
      send(32'h1234_5678, 1'b1, 1'b1, model_crc(32'h1234_5678, 1'b1, 1'b1) ^ 6'h20, 1'b0);
      check("hold_pos_out",  pos_out,   32'h0000_00F0);
      check("hold_delta",    pos_delta, 32'hFFFF_FFF0);
      check("hold_err_warn", {30'd0, enc_err, enc_warn}, 32'h0);
      check("hold_crc_err",  {31'd0, crc_err}, 32'd1);

      // Fault: 3 bad, 1 good, 3 bad, then a 4th consecutive bad
      send_good(32'h55, 1'b0, 1'b0);
      repeat (3) send_bad(32'hABC, 1'b0);
      send_good(32'h66, 1'b0, 1'b0);
      repeat (3) send_bad(32'hABC, 1'b0);
      check("f3_fault", {31'd0, fault}, 32'd0);
      send_bad(32'hABC, 1'b0);
      check("f4_fault",   {31'd0, fault}, 32'd1);
      check("f4_bad_cnt", {16'd0, bad_cnt}, 32'd9);
      pulse_clr();
      check("fclr_fault", {31'd0, fault}, 32'd0);
      check("fclr_keeps_bad_cnt", {16'd0, bad_cnt}, 32'd9);

      // Clear coinciding with the setting UPDATE: set wins
      send_good(32'h77, 1'b0, 1'b0);
      repeat (3) send_bad(32'hABC, 1'b0);
      send_bad(32'hABC, 1'b1);
      check("fset_wins", {31'd0, fault}, 32'd1);
      pulse_clr();
      check("fclr2_fault", {31'd0, fault}, 32'd0);

      // Overrun: second frame_valid 10 clocks into the first
      pv_before = pv_pulses;
      @(negedge clk);
      frame_valid      = 1'b1;
      enc_position_all = {1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0, model_crc(32'hA5A5_A5A5, 1'b0, 1'b0)};
      @(posedge clk);
      #1 frame_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      frame_valid      = 1'b1;
      enc_position_all = {1'b0, 32'h1111_1111, 1'b0, 1'b0, model_crc(32'h1111_1111, 1'b0, 1'b0)};
      @(posedge clk);
      #1 frame_valid = 1'b0;
      repeat (26) @(posedge clk);
      #1;
      check("ovr_flag",      {31'd0, overrun},   32'd1);
      check("ovr_pos_valid", {31'd0, pos_valid}, 32'd1);
      check("ovr_pos_out",   pos_out,   32'hA5A5_A5A5);
      check("ovr_delta",     pos_delta, 32'hA5A5_A5A5 - 32'h0000_0077);
      repeat (45) @(posedge clk);
      #1;
      check("ovr_one_pulse", pv_pulses - pv_before, 32'd1);
      pulse_clr();
      check("ovr_clr", {31'd0, overrun}, 32'd0);

      // Reset at E20 of a frame
      pv_before = pv_pulses;
      ce_before = ce_pulses;
      @(negedge clk);
      frame_valid      = 1'b1;
      enc_position_all = {1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, model_crc(32'h0BAD_F00D, 1'b0, 1'b0)};
      @(posedge clk);
      #1 frame_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check_reset_state("mid_rst");
      check("mid_rst_no_pv", pv_pulses - pv_before, 32'd0);
      check("mid_rst_no_ce", ce_pulses - ce_before, 32'd0);

      send_good(32'h0000_0777, 1'b0, 1'b0);
      check("post_rst_pos_out",  pos_out,   32'h0000_0777);
      check("post_rst_delta",    pos_delta, 32'd0);
      check("post_rst_good_cnt", {16'd0, good_cnt}, 32'd1);

      repeat (3) @(posedge clk);
      check("never_both_high", both_high, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
